// File: rtl/carry_select_adder_pipe.sv
// Pipelined, parametrised carry-select adder: sum = a + b + cin mod 2^WIDTH.
// The operand is cut into BLOCK-bit blocks. Block 0 ripples on cin. Every other block
// precomputes the sums for carry-in 0 and 1, then selects one with the incoming block carry.
// The blocks are spread over STAGES register stages, with valid/ready on both sides.
// Define CSA_PIPE_OVF_EN to add the signed-overflow output ovf. It is pipelined with sum.
module carry_select_adder_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned BLOCK  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CSA_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned BlkDiv   = (BLOCK == 0) ? 1 : BLOCK;
  localparam int unsigned WidthRem = WIDTH % BlkDiv;
  localparam int unsigned NumBlk   = WIDTH / BlkDiv;
  localparam int unsigned StgDiv   = (STAGES == 0) ? 1 : STAGES;
  // Every stage gets BlkPer blocks. The last stage also takes the remainder.
  localparam int unsigned BlkPer   = NumBlk / StgDiv;

  if (BLOCK == 0 || WidthRem != 0) begin : g_err_block
    $error("carry_select_adder_pipe: WIDTH must be a nonzero multiple of BLOCK");
  end
  if (STAGES < 1 || STAGES > NumBlk) begin : g_err_stages
    $error("carry_select_adder_pipe: STAGES must be in 1..WIDTH/BLOCK");
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int unsigned First = s * BlkPer;
    localparam int unsigned NBlk  = (s == STAGES - 1) ? NumBlk - First : BlkPer;
    localparam int unsigned Lo    = First * BLOCK;
    localparam int unsigned Hi    = (First + NBlk) * BLOCK;

    // Upstream view of this stage. Only the operand bits at or above Lo are still live.
    logic              up_v;
    logic              up_c;
    logic [WIDTH-1:Lo] up_a;
    logic [WIDTH-1:Lo] up_b;

    logic [Hi-1:Lo]    res;    // sum bits resolved by this stage
    logic [Hi-1:0]     sum_d;
    logic [Hi-1:0]     sum_q;
    logic              c_d;
    logic              c_q;
    logic              v_q;
    logic              take;   // downstream takes this stage's beat this cycle
    logic              rdy;    // this stage can load this cycle
    logic              load;

    if (s == 0) begin : g_src
      assign up_v  = in_valid;
      assign up_c  = cin;
      assign up_a  = a;
      assign up_b  = b;
      assign sum_d = res;
    end else begin : g_src
      assign up_v  = g_stage[s-1].v_q;
      assign up_c  = g_stage[s-1].c_q;
      assign up_a  = g_stage[s-1].g_ab.a_q;
      assign up_b  = g_stage[s-1].g_ab.b_q;
      assign sum_d = {res, g_stage[s-1].sum_q};
    end

    if (s == STAGES - 1) begin : g_dn
      assign take = out_ready;
    end else begin : g_dn
      assign take = g_stage[s+1].rdy;
    end

    // The ready path is combinational from out_ready back to in_ready.
    // A full pipe can therefore shift every stage in the same cycle.
    assign rdy  = ~v_q | take;
    assign load = rdy & up_v;

    for (genvar j = 0; j < NBlk; j++) begin : g_blk
      localparam int unsigned Bl = Lo + j * BLOCK;

      logic           bci;
      logic           bco;
      logic [BLOCK:0] s0;

      if (j == 0) begin : g_ci
        assign bci = up_c;
      end else begin : g_ci
        assign bci = g_blk[j-1].bco;
      end

      if (Bl == 0) begin : g_add
        // Block 0 sits right on cin, so a plain ripple add is the fastest choice.
        assign s0 = {1'b0, up_a[Bl +: BLOCK]} + {1'b0, up_b[Bl +: BLOCK]}
                  + {{BLOCK{1'b0}}, bci};
        assign {bco, res[Bl +: BLOCK]} = s0;
      end else begin : g_add
        logic [BLOCK:0] s1;
        assign s0 = {1'b0, up_a[Bl +: BLOCK]} + {1'b0, up_b[Bl +: BLOCK]};
        assign s1 = {1'b0, up_a[Bl +: BLOCK]} + {1'b0, up_b[Bl +: BLOCK]}
                  + {{BLOCK{1'b0}}, 1'b1};
        assign {bco, res[Bl +: BLOCK]} = bci ? s1 : s0;
      end
    end

    assign c_d = g_blk[NBlk-1].bco;

    // Stage valid updates whenever the stage can move. The payload updates only on a real load.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        sum_q <= '0;
        c_q   <= 1'b0;
      end else begin
        if (rdy) begin
          v_q <= up_v;
        end
        if (load) begin
          sum_q <= sum_d;
          c_q   <= c_d;
        end
      end
    end

    if (s < STAGES - 1) begin : g_ab
      logic [WIDTH-1:Hi] a_q;
      logic [WIDTH-1:Hi] b_q;

      // Carry forward only the operand bits that later stages still need.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (load) begin
          a_q <= up_a[WIDTH-1:Hi];
          b_q <= up_b[WIDTH-1:Hi];
        end
      end
    end

`ifdef CSA_PIPE_OVF_EN
    if (s == STAGES - 1) begin : g_ovf
      logic ovf_d;
      logic ovf_q;

      // Carry into the MSB is a^b^sum at that bit. Overflow is that carry XOR cout.
      assign ovf_d = up_a[WIDTH-1] ^ up_b[WIDTH-1] ^ res[WIDTH-1] ^ c_d;

      // Registered alongside the final sum so it has the same latency and hold behaviour.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (load) begin
          ovf_q <= ovf_d;
        end
      end
    end
`endif
  end

  assign in_ready  = g_stage[0].rdy;
  assign out_valid = g_stage[STAGES-1].v_q;
  assign sum       = g_stage[STAGES-1].sum_q;
  assign cout      = g_stage[STAGES-1].c_q;
`ifdef CSA_PIPE_OVF_EN
  assign ovf       = g_stage[STAGES-1].g_ovf.ovf_q;
`endif

endmodule

// File: tb/tb_carry_select_adder_pipe.sv
// Self-checking bench for carry_select_adder_pipe.
// It drives a 32/4/2 instance with directed vectors, back-pressure, full throughput and
// mid-stream reset. It also runs random valid/ready sweeps on 16/4/1, 32/8/4 and 64/4/3 instances.
// Overflow checks are included when CSA_PIPE_OVF_EN is defined.
module tb_carry_select_adder_pipe;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef CSA_PIPE_OVF_EN
  logic         ovf;
`endif

  int checks   = 0;
  int failures = 0;

  int           sent;
  int           got;
  int           last_c;
  logic         all_done;
  logic [W:0]   mq [$];

  // Directed vectors: a, b, cin -> sum, cout, ovf (hand computed).
  logic [W-1:0] dv_a [5] = '{32'h0000_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000,
                             32'h1234_5678};
  logic [W-1:0] dv_b [5] = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 32'h8000_0000,
                             32'h9ABC_DEF0};
  logic         dv_c [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [W-1:0] dv_s [5] = '{32'h0001_0000, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000,
                             32'hACF1_3568};
  logic         dv_co [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic         dv_o [5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] req);
    checks++;
    if (obs !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, req);
    end
  endtask

  carry_select_adder_pipe #(
    .WIDTH (W),
    .BLOCK (4),
    .STAGES(2)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout)
`ifdef CSA_PIPE_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  // Random sweeps on other geometries, each with its own reset and scoreboard.
  for (genvar k = 0; k < 3; k++) begin : g_sw
    localparam int unsigned SW = (k == 0) ? 16 : ((k == 1) ? 32 : 64);
    localparam int unsigned SB = (k == 1) ? 8 : 4;
    localparam int unsigned SS = (k == 0) ? 1 : ((k == 1) ? 4 : 3);

    logic          srst;
    logic          iv;
    logic          ir;
    logic          ci;
    logic          ov;
    logic          ordy;
    logic          co;
    logic          done;
    logic [SW-1:0] sa;
    logic [SW-1:0] sb;
    logic [SW-1:0] ss;
`ifdef CSA_PIPE_OVF_EN
    logic          so;
`endif
    logic [SW+1:0] q [$];

    carry_select_adder_pipe #(
      .WIDTH (SW),
      .BLOCK (SB),
      .STAGES(SS)
    ) u_dut (
      .clk      (clk),
      .rst_n    (srst),
      .in_valid (iv),
      .in_ready (ir),
      .a        (sa),
      .b        (sb),
      .cin      (ci),
      .out_valid(ov),
      .out_ready(ordy),
      .sum      (ss),
      .cout     (co)
`ifdef CSA_PIPE_OVF_EN
      ,
      .ovf      (so)
`endif
    );

    initial begin
      int            ns;
      int            ng;
      logic [63:0]   ra;
      logic [63:0]   rb;
      logic [SW:0]   t;
      logic [SW+1:0] e;
      ns = 0; ng = 0; done = 1'b0; srst = 1'b0;
      iv = 1'b0; ordy = 1'b0; sa = '0; sb = '0; ci = 1'b0;
      repeat (2) @(posedge clk);
      #1 srst = 1'b1;
      for (int c = 0; c < 2000 && ng < 60; c++) begin
        ra = {$urandom(), $urandom()};
        rb = {$urandom(), $urandom()};
        sa = ra[SW-1:0];
        // Every fourth beat or so, b is the complement of a to force a full carry chain.
        sb = ($urandom_range(3) == 0) ? ~sa : rb[SW-1:0];
        ci = 1'($urandom_range(1));
        iv = (ns < 60) && ($urandom_range(3) != 0);
        ordy = ($urandom_range(3) != 0);
        #1;
        if (ov && ordy) begin
          check($sformatf("sweep%0d_nonempty", k), 128'(q.size() > 0), 128'(1));
          if (q.size() > 0) begin
            e = q.pop_front();
            check($sformatf("sweep%0d_sum", k), 128'({co, ss}), 128'(e[SW:0]));
`ifdef CSA_PIPE_OVF_EN
            check($sformatf("sweep%0d_ovf", k), 128'(so), 128'(e[SW+1]));
`endif
          end
          ng++;
        end
        if (iv && ir) begin
          t = {1'b0, sa} + {1'b0, sb} + {{SW{1'b0}}, ci};
          e = {((sa[SW-1] == sb[SW-1]) && (t[SW-1] != sa[SW-1])), t};
          q.push_back(e);
          ns++;
        end
        @(posedge clk);
        #1;
      end
      check($sformatf("sweep%0d_count", k), 128'(ng), 128'(60));
      check($sformatf("sweep%0d_leftover", k), 128'(q.size()), 128'(0));
      iv = 1'b0;
      done = 1'b1;
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_sum", 128'(sum), 128'(0));
    check("rst_cout", 128'(cout), 128'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_idle_valid", 128'(out_valid), 128'(0));

    // Directed vectors, one at a time, checking exact two-cycle latency.
    for (int i = 0; i < 5; i++) begin
      a = dv_a[i]; b = dv_b[i]; cin = dv_c[i]; in_valid = 1'b1;
      #1;
      check($sformatf("dir%0d_in_ready", i), 128'(in_ready), 128'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check($sformatf("dir%0d_early", i), 128'(out_valid), 128'(0));
      @(posedge clk);
      #1;
      check($sformatf("dir%0d_valid", i), 128'(out_valid), 128'(1));
      check($sformatf("dir%0d_sum", i), 128'(sum), 128'(dv_s[i]));
      check($sformatf("dir%0d_cout", i), 128'(cout), 128'(dv_co[i]));
`ifdef CSA_PIPE_OVF_EN
      check($sformatf("dir%0d_ovf", i), 128'(ovf), 128'(dv_o[i]));
`endif
    end
    @(posedge clk);
    #1;

    // Back-pressure: beats i+i, out_ready low for the first 4 cycles.
    sent = 0; got = 0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      out_ready = (c >= 4);
      in_valid = (sent < 5);
      a = W'(sent); b = W'(sent); cin = 1'b0;
      #1;
      if (c == 2 || c == 3) check("bp_full_in_ready", 128'(in_ready), 128'(0));
      if (c == 3) begin
        check("bp_hold_valid", 128'(out_valid), 128'(1));
        check("bp_hold_sum", 128'(sum), 128'(0));
      end
      if (c == 4) check("bp_release_in_ready", 128'(in_ready), 128'(1));
      if (out_valid && out_ready) begin
        check("bp_order", 128'(sum), 128'(2 * got));
        got++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("bp_count", 128'(got), 128'(5));
    check("bp_sent", 128'(sent), 128'(5));
    #1;
    check("bp_empty", 128'(out_valid), 128'(0));

    // Full throughput: 100 random beats back to back.
    sent = 0; got = 0; last_c = 0; out_ready = 1'b1;
    for (int c = 0; c < 300 && got < 100; c++) begin
      in_valid = (sent < 100);
      a = $urandom(); b = $urandom(); cin = 1'($urandom_range(1));
      #1;
      if (out_valid) begin
        check("tp_nonempty", 128'(mq.size() > 0), 128'(1));
        if (mq.size() > 0) check("tp_sum", 128'({cout, sum}), 128'(mq.pop_front()));
        got++;
        last_c = c;
      end
      if (in_valid && in_ready) begin
        mq.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin});
        sent++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("tp_count", 128'(got), 128'(100));
    check("tp_cycles", 128'(last_c), 128'(101));
    @(posedge clk);
    #1;

    // Reset with two beats in flight.
    a = 32'd1; b = 32'd2; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    a = 32'd3; b = 32'd4;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("mr_pre_valid", 128'(out_valid), 128'(1));
    check("mr_pre_sum", 128'(sum), 128'(3));
    rst_n = 1'b0;
    #1;
    check("mr_valid", 128'(out_valid), 128'(0));
    check("mr_sum", 128'(sum), 128'(0));
    check("mr_cout", 128'(cout), 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("mr_in_ready", 128'(in_ready), 128'(1));
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      check("mr_no_stale", 128'(out_valid), 128'(0));
    end

    all_done = 1'b0;
    for (int t = 0; t < 20000 && !all_done; t++) begin
      @(posedge clk);
      all_done = g_sw[0].done & g_sw[1].done & g_sw[2].done;
    end
    check("sweep_done", 128'(all_done), 128'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
